// File: rtl/mux8_scan_ctrl.sv
// rtl/mux8_scan_ctrl.sv - 8-to-1 mux scan sequencer: holds a word and steps select through a frame (optional MUX8_SCAN_REPEAT_EN adds i_repeat)
module mux8_scan_ctrl #(
    parameter int BIT_CYCLES = 1,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
`ifdef MUX8_SCAN_REPEAT_EN
    input  logic       i_repeat,
`endif
    input  logic       load_valid,
    input  logic [7:0] load_data,
    output logic       load_ready,
    output logic [7:0] mux_in,
    output logic [2:0] s,
    output logic       en_bar,
    output logic       busy,
    output logic       done
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    localparam logic [2:0] S_START = MSB_FIRST ? 3'd7 : 3'd0;
    localparam logic [7:0] CNT_MAX = 8'(BIT_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_mux_in;
    logic [2:0] r_s;
    logic       r_en_bar;
    logic       r_busy;
    logic       r_done;
    logic [2:0] r_idx;
    logic [7:0] r_cnt;

    logic       w_repeat;
    logic       w_accept;
    logic       w_cnt_wrap;
    logic       w_last;
    state_t     w_next_state;
    logic [2:0] w_nxt_idx;
    logic [7:0] w_nxt_cnt;
    logic       w_done_nxt;

`ifdef MUX8_SCAN_REPEAT_EN
    assign w_repeat = i_repeat;
`else
    assign w_repeat = 1'b0;
`endif

    assign load_ready = (r_state == ST_IDLE);
    assign mux_in     = r_mux_in;
    assign s          = r_s;
    assign en_bar     = r_en_bar;
    assign busy       = r_busy;
    assign done       = r_done;

    // Next bit index / hold counter and look-ahead of the final frame cycle so done is registered
    always_comb begin
        w_accept     = (r_state == ST_IDLE) && load_valid;
        w_cnt_wrap   = (r_cnt == CNT_MAX);
        w_last       = (r_state == ST_SHIFT) && w_cnt_wrap && (r_idx == 3'd7);
        w_nxt_idx    = 3'd0;
        w_nxt_cnt    = 8'd0;
        w_next_state = r_state;
        if (r_state == ST_SHIFT) begin
            if (w_cnt_wrap) begin
                w_nxt_idx = r_idx + 3'd1;
                w_nxt_cnt = 8'd0;
            end else begin
                w_nxt_idx = r_idx;
                w_nxt_cnt = r_cnt + 8'd1;
            end
        end
        if (w_accept) begin
            w_next_state = ST_SHIFT;
        end else if (w_last && !w_repeat) begin
            w_next_state = ST_IDLE;
        end
        w_done_nxt = (w_next_state == ST_SHIFT) && (w_nxt_idx == 3'd7) && (w_nxt_cnt == CNT_MAX);
    end

    // Frame FSM: capture on accept, step select on each counter wrap, release enable after bit 7
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_mux_in <= 8'h00;
            r_s      <= S_START;
            r_en_bar <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_idx    <= 3'd0;
            r_cnt    <= 8'd0;
        end else begin
            r_state <= w_next_state;
            r_idx   <= w_nxt_idx;
            r_cnt   <= w_nxt_cnt;
            r_done  <= w_done_nxt;
            case (r_state)
                ST_IDLE: begin
                    r_s <= S_START;
                    if (w_accept) begin
                        r_mux_in <= load_data;
                        r_en_bar <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (w_last) begin
                        // Restart at START either for a repeated frame or for the idle position
                        r_s <= S_START;
                        if (!w_repeat) begin
                            r_en_bar <= 1'b1;
                            r_busy   <= 1'b0;
                        end
                    end else if (w_cnt_wrap) begin
                        r_s <= MSB_FIRST ? (r_s - 3'd1) : (r_s + 3'd1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// tb/tb_mux8_scan_ctrl.sv - self-checking bench for mux8_scan_ctrl
module tb_mux8_scan_ctrl;

    typedef struct packed {
        logic [7:0] word;
        logic [2:0] s;
        logic       b;
        logic       done;
    } exp_t;

    logic       clk;
    logic       rst_r  [3];
    logic       lv     [3];
    logic [7:0] ld     [3];
    logic       rep    [3];
    logic       rdy_w  [3];
    logic [7:0] mi_w   [3];
    logic [2:0] s_w    [3];
    logic       en_w   [3];
    logic       busy_w [3];
    logic       done_w [3];

    int bc_of    [3] = '{1, 3, 2};
    bit msb_of   [3] = '{1'b0, 1'b1, 1'b0};

    exp_t q[$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    mux8_scan_ctrl #(.BIT_CYCLES(1), .MSB_FIRST(1'b0)) u_dut0 (
        .clk(clk), .rst(rst_r[0]),
`ifdef MUX8_SCAN_REPEAT_EN
        .i_repeat(rep[0]),
`endif
        .load_valid(lv[0]), .load_data(ld[0]), .load_ready(rdy_w[0]),
        .mux_in(mi_w[0]), .s(s_w[0]), .en_bar(en_w[0]), .busy(busy_w[0]), .done(done_w[0])
    );

    mux8_scan_ctrl #(.BIT_CYCLES(3), .MSB_FIRST(1'b1)) u_dut1 (
        .clk(clk), .rst(rst_r[1]),
`ifdef MUX8_SCAN_REPEAT_EN
        .i_repeat(rep[1]),
`endif
        .load_valid(lv[1]), .load_data(ld[1]), .load_ready(rdy_w[1]),
        .mux_in(mi_w[1]), .s(s_w[1]), .en_bar(en_w[1]), .busy(busy_w[1]), .done(done_w[1])
    );

    mux8_scan_ctrl #(.BIT_CYCLES(2), .MSB_FIRST(1'b0)) u_dut2 (
        .clk(clk), .rst(rst_r[2]),
`ifdef MUX8_SCAN_REPEAT_EN
        .i_repeat(rep[2]),
`endif
        .load_valid(lv[2]), .load_data(ld[2]), .load_ready(rdy_w[2]),
        .mux_in(mi_w[2]), .s(s_w[2]), .en_bar(en_w[2]), .busy(busy_w[2]), .done(done_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] start_of(input int d);
        return msb_of[d] ? 3'd7 : 3'd0;
    endfunction

    task automatic push_frame(input logic [7:0] w, input int d);
        logic [2:0] p;
        exp_t       e;
        for (int k = 0; k < 8; k++) begin
            p = msb_of[d] ? 3'(7 - k) : 3'(k);
            for (int c = 0; c < bc_of[d]; c++) begin
                e.word = w;
                e.s    = p;
                e.b    = w[p];
                e.done = (k == 7) && (c == bc_of[d] - 1);
                q.push_back(e);
            end
        end
    endtask

    task automatic check_idle(input string tag, input int d, input logic [7:0] w);
        chk({tag, "_en_bar"}, en_w[d], 1'b1);
        chk({tag, "_busy"}, busy_w[d], 1'b0);
        chk({tag, "_done"}, done_w[d], 1'b0);
        chk({tag, "_s"}, s_w[d], start_of(d));
        chk({tag, "_ready"}, rdy_w[d], 1'b1);
        chk({tag, "_mux_in"}, mi_w[d], w);
    endtask

    // Called at the negedge of the first frame cycle; consumes the queue one cycle per entry
    task automatic check_frame(input string tag, input int d, input bit tail);
        exp_t e;
        while (q.size() > 0) begin
            e = q.pop_front();
            chk({tag, "_en_bar"}, en_w[d], 1'b0);
            chk({tag, "_busy"}, busy_w[d], 1'b1);
            chk({tag, "_ready"}, rdy_w[d], 1'b0);
            chk({tag, "_mux_in"}, mi_w[d], e.word);
            chk({tag, "_s"}, s_w[d], e.s);
            chk({tag, "_serial"}, mi_w[d][s_w[d]], e.b);
            chk({tag, "_done"}, done_w[d], e.done);
            if (done_w[d] === 1'b1) done_cnt++;
            @(negedge clk);
        end
        if (tail) check_idle({tag, "_tail"}, d, e.word);
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_r[i] = 1'b1;
            lv[i]    = 1'b1;
            ld[i]    = 8'hEE;
            rep[i]   = 1'b0;
        end
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) check_idle($sformatf("reset%0d", i), i, 8'h00);
        for (int i = 0; i < 3; i++) begin
            lv[i]    = 1'b0;
            rst_r[i] = 1'b0;
        end
        @(negedge clk);

        // LSB-first, one cycle per bit, 8'hA5
        lv[0] = 1'b1; ld[0] = 8'hA5;
        push_frame(8'hA5, 0);
        @(negedge clk);
        lv[0] = 1'b0;
        done_cnt = 0;
        check_frame("a5", 0, 1'b1);
        chk("a5_done_count", done_cnt, 1);

        // MSB-first, three cycles per bit, 8'h3C
        lv[1] = 1'b1; ld[1] = 8'h3C;
        push_frame(8'h3C, 1);
        @(negedge clk);
        lv[1] = 1'b0;
        check_frame("3c", 1, 1'b1);

        // Word offered during a frame waits until the first idle cycle after done
        lv[0] = 1'b1; ld[0] = 8'h01;
        push_frame(8'h01, 0);
        @(negedge clk);
        ld[0] = 8'hFF;
        check_frame("hold01", 0, 1'b1);
        push_frame(8'hFF, 0);
        @(negedge clk);
        lv[0] = 1'b0;
        check_frame("ff", 0, 1'b1);

        // Back-to-back frames with valid held: 16 low, 1 high, 16 low
        lv[2] = 1'b1; ld[2] = 8'h81;
        push_frame(8'h81, 2);
        @(negedge clk);
        ld[2] = 8'h7E;
        done_cnt = 0;
        check_frame("b2b81", 2, 1'b1);
        push_frame(8'h7E, 2);
        @(negedge clk);
        lv[2] = 1'b0;
        check_frame("b2b7e", 2, 1'b1);
        chk("b2b_done_count", done_cnt, 2);

        // Reset in the middle of a frame at bit 3
        lv[0] = 1'b1; ld[0] = 8'hAA;
        @(negedge clk);
        lv[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("midrst_pre_s", s_w[0], 3'd3);
        chk("midrst_pre_en_bar", en_w[0], 1'b0);
        rst_r[0] = 1'b1;
        #1;
        chk("midrst_en_bar", en_w[0], 1'b1);
        chk("midrst_s", s_w[0], 3'd0);
        chk("midrst_busy", busy_w[0], 1'b0);
        chk("midrst_done", done_w[0], 1'b0);
        @(negedge clk);
        rst_r[0] = 1'b0;
        @(negedge clk);
        check_idle("postrst", 0, 8'h00);
        @(negedge clk);
        chk("postrst_en_bar_hold", en_w[0], 1'b1);

`ifdef MUX8_SCAN_REPEAT_EN
        // Repeat: three gapless frames of 8'h55, then back to idle
        rep[0] = 1'b1;
        lv[0] = 1'b1; ld[0] = 8'h55;
        push_frame(8'h55, 0);
        push_frame(8'h55, 0);
        @(negedge clk);
        lv[0] = 1'b0;
        done_cnt = 0;
        check_frame("rep12", 0, 1'b0);
        rep[0] = 1'b0;
        push_frame(8'h55, 0);
        check_frame("rep3", 0, 1'b1);
        chk("rep_done_count", done_cnt, 3);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
